// File: rtl/alu_seq_pkg.sv
// Shared opcodes, ALU encodings and FSM states for the sequenced ALU front-end.
package alu_seq_pkg;

    localparam int N_DEFAULT = 12;

    // Request opcodes
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_CLC = 2'b11;

    // Downstream ALU opcodes
    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PASS1 = 2'b01,
        ST_PASS2 = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    // ADD and ADC both drive the ALU adder; only AND uses the AND path.
    function automatic logic [1:0] alu_op_for(input logic [1:0] op);
        return (op == OP_AND) ? ALU_AND : ALU_ADD;
    endfunction

endpackage

// File: rtl/alu_seq.sv
// Sequences AND/ADD/ADC/CLC requests through an external combinational ALU, tracking a carry flag.
// Latency from accept edge to response: CLC 1, AND/ADD 2, ADC 3 cycles.
// Response held stable until rsp_ready; req_ready only in IDLE or when the pending response drains.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    output logic [N-1:0] alu_in0,
    output logic [N-1:0] alu_in1,
    output logic [1:0]   alu_op,
    input  logic [N-1:0] alu_out,
    input  logic         alu_cy,
    input  logic         alu_zero,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         rsp_cy,
    output logic         rsp_zero,
    output logic         flag_c,
    output logic         busy
);

    state_t     state;
    logic [1:0] op_r;
    logic       cy_snap;
    logic       cy1;
    logic       accept;

    assign req_ready = (state == ST_IDLE) | ((state == ST_RESP) & rsp_ready);
    assign accept    = req_valid & req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_r      <= OP_AND;
            cy_snap   <= 1'b0;
            cy1       <= 1'b0;
            alu_in0   <= '0;
            alu_in1   <= '0;
            alu_op    <= ALU_AND;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_cy    <= 1'b0;
            rsp_zero  <= 1'b0;
            flag_c    <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            // flag_c here already reflects a response completing this same edge
            op_r    <= req_op;
            cy_snap <= flag_c;
            alu_in0 <= req_a;
            alu_in1 <= req_b;
            alu_op  <= alu_op_for(req_op);
            busy    <= 1'b1;
            if (req_op == OP_CLC) begin
                state     <= ST_RESP;
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
                rsp_cy    <= 1'b0;
                rsp_zero  <= 1'b1;
                flag_c    <= 1'b0;
            end else begin
                state     <= ST_PASS1;
                rsp_valid <= 1'b0;
            end
        end else begin
            case (state)
                ST_PASS1: begin
                    if (op_r == OP_ADC) begin
                        // Second pass folds the snapshotted carry into the first-pass sum
                        state   <= ST_PASS2;
                        cy1     <= alu_cy;
                        alu_in0 <= alu_out;
                        alu_in1 <= {{(N-1){1'b0}}, cy_snap};
                        alu_op  <= ALU_ADD;
                    end else begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= alu_out;
                        rsp_zero  <= alu_zero;
                        rsp_cy    <= (op_r == OP_ADD) & alu_cy;
                        if (op_r == OP_ADD) begin
                            flag_c <= alu_cy;
                        end
                    end
                end
                ST_PASS2: begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= alu_out;
                    rsp_zero  <= alu_zero;
                    rsp_cy    <= cy1 | alu_cy;
                    flag_c    <= cy1 | alu_cy;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: combinational ALU stub, vector table with scoreboard, stall and reset sequences.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int N = 12;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req_valid, req_ready, rsp_valid, rsp_ready;
    logic [1:0]   req_op, alu_op;
    logic [N-1:0] req_a, req_b, alu_in0, alu_in1, alu_out, rsp_data;
    logic         alu_cy, alu_zero, rsp_cy, rsp_zero, flag_c, busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [1:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] data;
        logic         cy;
        logic         zero;
        logic         flag;
        int           lat;
    } vec_t;

    typedef struct {
        logic [N-1:0] data;
        logic         cy;
        logic         zero;
        logic         flag;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[13];

    alu_seq #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_op(alu_op),
        .alu_out(alu_out), .alu_cy(alu_cy), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_cy(rsp_cy), .rsp_zero(rsp_zero),
        .flag_c(flag_c), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU stub; the AND path raises a spurious carry so a leaked carry is visible.
    always_comb begin
        alu_out = '0;
        alu_cy  = 1'b0;
        case (alu_op)
            ALU_AND: begin
                alu_out = alu_in0 & alu_in1;
                alu_cy  = |(alu_in0 & alu_in1);
            end
            ALU_ADD: {alu_cy, alu_out} = {1'b0, alu_in0} + {1'b0, alu_in1};
            default: begin
            end
        endcase
        alu_zero = (alu_out == '0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                          input bit push, input exp_t e);
        int w;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: req_ready stayed 0 for %0d cycles", w);
            req_valid = 1'b0;
            return;
        end
        if (push) begin
            e.acc = cyc + 1;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sbq.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("drain_pending", sbq.size(), 0);
        @(negedge clk);
    endtask

    // Scoreboard monitor: compares each response on the cycle its handshake is set up.
    initial begin
        exp_t e;
        int   first_cyc;
        bit   need_first;
        need_first = 1'b1;
        first_cyc  = 0;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                if (need_first) begin
                    first_cyc  = cyc;
                    need_first = 1'b0;
                end
                if (rsp_ready) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: data 0x%0h with no request pending", rsp_data);
                    end else begin
                        e = sbq.pop_front();
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_cy", rsp_cy, e.cy);
                        chk("rsp_zero", rsp_zero, e.zero);
                        chk("flag_c", flag_c, e.flag);
                        chk("latency", first_cyc - e.acc + 1, e.lat);
                    end
                    need_first = 1'b1;
                end
            end
        end
    end

    initial begin
        exp_t e;
        int   w;
        int   seen;

        vecs[0]  = '{OP_ADD, 12'h800, 12'h800, 12'h000, 1'b1, 1'b1, 1'b1, 2};
        vecs[1]  = '{OP_ADC, 12'h001, 12'h002, 12'h004, 1'b0, 1'b0, 1'b0, 3};
        vecs[2]  = '{OP_ADD, 12'hFFF, 12'h001, 12'h000, 1'b1, 1'b1, 1'b1, 2};
        vecs[3]  = '{OP_ADC, 12'hFFF, 12'h000, 12'h000, 1'b1, 1'b1, 1'b1, 3};
        vecs[4]  = '{OP_AND, 12'hF0F, 12'h0FF, 12'h00F, 1'b0, 1'b0, 1'b1, 2};
        vecs[5]  = '{OP_CLC, 12'h5A5, 12'hA5A, 12'h000, 1'b0, 1'b1, 1'b0, 1};
        vecs[6]  = '{OP_ADC, 12'h7FF, 12'h7FF, 12'hFFE, 1'b0, 1'b0, 1'b0, 3};
        vecs[7]  = '{OP_ADD, 12'h123, 12'h456, 12'h579, 1'b0, 1'b0, 1'b0, 2};
        vecs[8]  = '{OP_ADC, 12'hFFF, 12'hFFF, 12'hFFE, 1'b1, 1'b0, 1'b1, 3};
        vecs[9]  = '{OP_ADC, 12'h000, 12'h000, 12'h001, 1'b0, 1'b0, 1'b0, 3};
        vecs[10] = '{OP_AND, 12'h000, 12'hFFF, 12'h000, 1'b0, 1'b1, 1'b0, 2};
        vecs[11] = '{OP_ADD, 12'h001, 12'hFFF, 12'h000, 1'b1, 1'b1, 1'b1, 2};
        vecs[12] = '{OP_CLC, 12'h000, 12'h000, 12'h000, 1'b0, 1'b1, 1'b0, 1};

        req_valid = 1'b0;
        req_op    = OP_AND;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {rsp_valid, rsp_cy, rsp_zero, flag_c, busy, alu_op}, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_alu_in", {alu_in0, alu_in1}, 0);
        rst_n = 1'b1;
        #1 chk("rst_req_ready", req_ready, 1);

        // Vector table, issued back-to-back
        for (int i = 0; i < 13; i++) begin
            e = '{vecs[i].data, vecs[i].cy, vecs[i].zero, vecs[i].flag, vecs[i].lat, 0};
            do_req(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, e);
        end
        drain();

        // Response stall, then same-edge hand-over to a new ADC
        rsp_ready = 1'b0;
        do_req(OP_ADD, 12'h0F0, 12'h00F, 1'b1, '{12'h0FF, 1'b0, 1'b0, 1'b0, 2, 0});
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!rsp_valid && w < 20);
        chk("stall_rsp_valid", rsp_valid, 1);
        req_valid = 1'b1;
        req_op    = OP_ADC;
        req_a     = 12'h100;
        req_b     = 12'h200;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_hold", {rsp_valid, rsp_cy, rsp_zero, rsp_data}, {3'b100, 12'h0FF});
            chk("stall_req_ready", req_ready, 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("b2b_req_ready", req_ready, 1);
        e = '{12'h300, 1'b0, 1'b0, 1'b0, 3, 0};
        e.acc = cyc + 1;
        sbq.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_no_idle", {busy, rsp_valid}, 2'b10);
        drain();

        // Reset during PASS2 of an ADC with flag_c set
        do_req(OP_ADD, 12'h800, 12'h800, 1'b1, '{12'h000, 1'b1, 1'b1, 1'b1, 2, 0});
        drain();
        do_req(OP_ADC, 12'h001, 12'h002, 1'b0, e);
        @(posedge clk);
        #1;
        chk("pass2_alu_in0", alu_in0, 12'h003);
        chk("pass2_alu_in1", alu_in1, 12'h001);
        chk("pass2_alu_op", alu_op, ALU_ADD);
        rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", {rsp_valid, rsp_cy, rsp_zero, flag_c, busy, alu_op}, 0);
        chk("midrst_data", {rsp_data, alu_in0, alu_in1}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("midrst_req_ready", req_ready, 1);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("midrst_no_rsp", seen, 0);
        do_req(OP_ADD, 12'h00A, 12'h005, 1'b1, '{12'h00F, 1'b0, 1'b0, 1'b0, 2, 0});
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter N, default 12, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  request accepted when req_valid & req_ready at a clk edge.
REQ-006 req_op  input  2  00 AND, 01 ADD, 10 ADC (add with stored carry), 11 CLC (clear carry).
REQ-007 req_a, req_b  input  N each  operands.
REQ-008 alu_in0, alu_in1  output  N each  operands driven to the downstream ALU.
REQ-009 alu_op  output  2  ALU opcode (00 AND, 01 ADD only).
REQ-010 alu_out  input  N, alu_cy  input  1, alu_zero  input  1  combinational ALU results.
REQ-011 rsp_valid  output  1, rsp_ready  input  1  response handshake.
REQ-012 rsp_data  output  N, rsp_cy  output  1, rsp_zero  output  1  response payload.
REQ-013 flag_c  output  1  architectural carry flag.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The block SHALL implement FSM states IDLE, PASS1, PASS2, RESP.
REQ-016 req_ready SHALL equal (state==IDLE) | (state==RESP & rsp_ready).
REQ-017 On accept, the block SHALL register op, req_a, req_b and a snapshot of flag_c; AND/ADD/ADC go to PASS1, CLC goes to RESP.
REQ-018 alu_in0/alu_in1/alu_op SHALL be driven only from registers, never combinationally from req_*.
REQ-019 PASS1: alu_op=00 for AND, 01 for ADD/ADC, inputs = registered a, b; result sampled at end of PASS1.
REQ-020 After PASS1, AND/ADD SHALL go to RESP; ADC SHALL go to PASS2 with alu_in0=PASS1 sum, alu_in1=zero-extended carry snapshot, alu_op=01.
REQ-021 Latency: accept at edge 0 -> rsp_valid high after edge 2 (AND/ADD), after edge 3 (ADC), after edge 1 (CLC).
REQ-022 ADD: rsp_cy=alu_cy of PASS1; ADC: rsp_cy=PASS1 carry OR PASS2 carry; AND and CLC: rsp_cy=0 (ALU carry ignored for AND).
REQ-023 rsp_zero SHALL be alu_zero sampled in the final ALU pass; CLC returns rsp_data=0, rsp_zero=1.
REQ-024 flag_c SHALL update to rsp_cy when entering RESP for ADD/ADC, clear for CLC, remain unchanged for AND.
REQ-025 In RESP, rsp_valid=1 and payload SHALL remain stable until rsp_ready; on rsp_ready the block returns to IDLE, or, if req_valid same cycle, accepts the new request directly (back-to-back).
REQ-026 A back-to-back ADC SHALL snapshot the flag_c value already updated by the completing response.
REQ-027 req_valid outside accept windows SHALL have no effect; no request buffering.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, rsp_valid=0, rsp_data=0, rsp_cy=0, rsp_zero=0, flag_c=0, alu_in0=alu_in1=0, alu_op=00, busy=0.
REQ-029 Reset mid-operation SHALL discard the in-flight request with no response emitted.
REQ-030 After rst_n deasserts, req_ready SHALL be 1 at the first edge.

Structure
REQ-031 Package alu_seq_pkg SHALL hold opcode constants (AND, ADD, ADC, CLC), ALU opcode constants, FSM state encoding, default N.
REQ-032 No sub-module; the ALU is instantiated by the parent and connected via alu_* ports.

Verification (N=12)
REQ-033 ADD 0x800+0x800 -> rsp_data 0x000, rsp_cy 1, rsp_zero 1, flag_c 1, rsp_valid two cycles after accept.
REQ-034 Then ADC 0x001+0x002 with flag_c=1 -> rsp_data 0x004, rsp_cy 0, rsp_zero 0, flag_c 0, three-cycle latency.
REQ-035 ADC 0xFFF+0x000 with flag_c=1 -> rsp_data 0x000, rsp_cy 1, rsp_zero 1; then AND 0xF0F&0x0FF -> 0x00F, rsp_cy 0, flag_c stays 1.
REQ-036 rsp_ready low 3 cycles in RESP -> payload stable, req_ready 0; then rsp_ready=1 with req_valid=1 -> new request accepted same edge, no idle cycle.
REQ-037 rst_n asserted during PASS2 of ADC -> all outputs zero immediately, no response after release, next ADD completes normally.
REQ-038 CLC with flag_c=1 -> rsp_data 0, rsp_zero 1, flag_c 0, one-cycle latency.
